clock_set_ctrl: RTL
===================

# clock_set_ctrl

Parametrised set-mode controller for the digital clock: the successor to the three-field switch state machine. It turns three debounced push-switches into per-field increment pulses, a seconds-clear pulse and per-field blink enables. The field count is configurable, and it adds switch edge detection, an inactivity timeout and optional auto-repeat. It sits between the switch debouncers and the sec/min/hour (and optional day) counters and display blanking.

## Interface
- NFIELD, 3, number of time fields (2..8); field 0 = seconds, 1 = minutes, 2 = hours, 3+ = higher fields
- TIMEOUT, 30, SEC_TICK count with no switch edge in SET before forced return to NORMAL; 0 disables timeout
- REPEAT_DELAY, 2, BLINK_TICK count SW2 must be held before auto-repeat starts (used only with CLOCK_SET_REPEAT_EN)

- CLK  in  1  system clock, all state on rising edge
- RESETL  in  1  reset; asynchronous and active-low
- SW1  in  1  mode switch (debounced, synchronous to CLK)
- SW2  in  1  adjust switch
- SW3  in  1  field-select switch
- SEC_TICK  in  1  one-cycle pulse, 1 Hz
- BLINK_TICK  in  1  one-cycle pulse, blink half-period (2 Hz)
- sec_resetl  out  1  active-low one-cycle pulse: clear seconds
- field_inc  out  NFIELD  one-cycle increment pulse per field; bit 0 is always 0
- field_onoff  out  NFIELD  display enable per field (1 = lit)
- set_mode  out  1  1 while in SET
- cur_field  out  $clog2(NFIELD)  selected field index (0 in NORMAL)

## Operation
- Per-switch rising edge: edge = SWn & ~prev_n. The prev registers reset to 1, so a switch held through reset produces no edge.
- States: NORMAL, SET(idx). The register encodes 0 = NORMAL and k = SET(k-1).
- NORMAL:
  - SW1 edge -> SET(0).
  - SW2 and SW3 edges are ignored.
  - All field_onoff bits are 1.
- SET(idx):
  - SW1 edge -> NORMAL.
  - SW3 edge -> SET((idx-1) mod NFIELD). For NFIELD=3 the order is sec -> hour -> min -> sec.
  - SW2 edge at idx=0 -> sec_resetl low for 1 cycle.
  - SW2 edge at idx>0 -> field_inc[idx] high for 1 cycle.
- Simultaneous edges use priority SW1 > SW3 > SW2. A lower-priority edge in the same cycle is dropped.
- Blink:
  - The phase register toggles on BLINK_TICK.
  - It is forced to 1 on entering SET, on any field change and on any SW2 edge.
  - field_onoff[idx] = phase; all other bits are 1.
- Timeout:
  - The counter clears on any switch edge and on entering SET.
  - It increments on SEC_TICK while in SET.
  - When it reaches TIMEOUT, the block goes to NORMAL with no pulse emitted.
- Reset values:
  - state = NORMAL.
  - sec_resetl = 1, field_inc = 0, field_onoff = all 1s.
  - set_mode = 0, cur_field = 0.
  - Phase = 1, counters = 0.

## Timing
- All outputs are registered.
- A switch edge sampled at clock edge t gives state, pulses and cur_field valid from t+1; pulses last exactly one cycle.
- Back-to-back SW2 edges (e.g. SW2 = 1,0,1) give one pulse per rising edge; no edge is lost.
- RESETL asserted mid-operation returns all outputs to their reset values immediately and asynchronously. Any pending pulse is cancelled.
- SEC_TICK and BLINK_TICK in the same cycle as a switch edge: the edge is processed and the timeout counter clears, and SEC_TICK does not increment it. The blink phase is forced to 1, overriding any BLINK_TICK toggle.

## Configuration
- CLOCK_SET_REPEAT_EN defined:
  - While SW2 stays high at idx>0, a hold counter counts BLINK_TICKs.
  - After REPEAT_DELAY ticks, each further BLINK_TICK gives one field_inc[idx] pulse.
  - The hold clears on SW2 low or a field/state change. It does not clear the timeout.
  - No repeat at idx=0.
- Undefined: no hold counter is present; one pulse per SW2 edge only.

## Structure
- Package clock_pkg holds:
  - the state encoding constants (ST_NORMAL = 0);
  - field indices FIELD_SEC = 0, FIELD_MIN = 1, FIELD_HOUR = 2;
  - a helper for the state-register width.
- One sub-module, sw_edge: a single-bit rising-edge detector with reset-to-1 prev. It is instantiated three times.

## Test plan
- Reset, then SW1 pulse. Required: set_mode = 1 and cur_field = 0 at t+1. Then three SW3 pulses. Required: cur_field = 2, 1, 0.
- SET(0): SW2 pulse -> sec_resetl = 0 for exactly 1 cycle. SET(2): SW2 pulse -> field_inc = 3'b100 for 1 cycle. NORMAL: SW2 pulse -> no output.
- SW1 and SW3 rising in the same cycle while in SET(1) -> NORMAL, cur_field = 0.
- TIMEOUT=3, SET(1), no switch activity -> NORMAL on the cycle after the 3rd SEC_TICK. An SW2 press after the 2nd tick delays the return by 3 further ticks.
- SET(1) with BLINK_TICK every 4 cycles -> field_onoff[1] toggles while bits 0 and 2 stay 1. An SW2 edge forces field_onoff[1] = 1.
- With CLOCK_SET_REPEAT_EN, REPEAT_DELAY=2: hold SW2 for 5 BLINK_TICKs in SET(2) -> 1 edge pulse + 3 repeat pulses on field_inc[2]. RESETL low mid-hold -> outputs reset and no further pulses.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and width helpers for the clock set-mode controller
package clock_pkg;

    localparam int ST_NORMAL  = 0;

    localparam int FIELD_SEC  = 0;
    localparam int FIELD_MIN  = 1;
    localparam int FIELD_HOUR = 2;

    // State register holds 0 for NORMAL and k for SET(k-1), so it needs NFIELD+1 codes
    function automatic int state_w(input int nfield);
        return $clog2(nfield + 1);
    endfunction

    function automatic int cnt_w(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - switch/tick inputs and field control outputs of the set-mode controller
interface clock_set_ctrl_if #(
    parameter int NFIELD = 3
);
    localparam int CW = (NFIELD < 2) ? 1 : $clog2(NFIELD);

    logic              SW1;
    logic              SW2;
    logic              SW3;
    logic              SEC_TICK;
    logic              BLINK_TICK;
    logic              sec_resetl;
    logic [NFIELD-1:0] field_inc;
    logic [NFIELD-1:0] field_onoff;
    logic              set_mode;
    logic [CW-1:0]     cur_field;

    modport master (
        output SW1, SW2, SW3, SEC_TICK, BLINK_TICK,
        input  sec_resetl, field_inc, field_onoff, set_mode, cur_field
    );

    modport slave (
        input  SW1, SW2, SW3, SEC_TICK, BLINK_TICK,
        output sec_resetl, field_inc, field_onoff, set_mode, cur_field
    );

endinterface

// File: rtl/sw_edge.sv
// rtl/sw_edge.sv - single-bit rising-edge detector whose history resets high
module sw_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    // Reset to 1 so a switch already held when reset releases is not seen as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - set-mode controller: field select, increment/clear pulses, blink, timeout
// Optional auto-repeat of SW2 on held switch: CLOCK_SET_REPEAT_EN
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int NFIELD       = 3,
    parameter int TIMEOUT      = 30,
    parameter int REPEAT_DELAY = 2
) (
    input  logic           CLK,
    input  logic           RESETL,
    clock_set_ctrl_if.slave bus
);

    localparam int SW_W = state_w(NFIELD);
    localparam int CW   = (NFIELD < 2) ? 1 : $clog2(NFIELD);
    localparam int TW   = cnt_w(TIMEOUT);

    logic e1, e2, e3;

    sw_edge u_sw1 (.clk(CLK), .rst_n(RESETL), .d(bus.SW1), .rise(e1));
    sw_edge u_sw2 (.clk(CLK), .rst_n(RESETL), .d(bus.SW2), .rise(e2));
    sw_edge u_sw3 (.clk(CLK), .rst_n(RESETL), .d(bus.SW3), .rise(e3));

    logic [SW_W-1:0]   state_q, state_d;
    logic              phase_q, phase_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              sec_resetl_q, sec_resetl_d;
    logic [NFIELD-1:0] field_inc_q, field_inc_d;
    logic [NFIELD-1:0] field_onoff_q, field_onoff_d;
    logic              set_mode_q, set_mode_d;
    logic [CW-1:0]     cur_field_q, cur_field_d;
    logic [CW-1:0]     new_idx;
    logic              in_set;

`ifdef CLOCK_SET_REPEAT_EN
    localparam int HW = cnt_w(REPEAT_DELAY);
    logic [HW-1:0] hold_q, hold_d;
`else
    localparam int unused_repeat_delay = REPEAT_DELAY;
`endif

    always_comb begin
        state_d      = state_q;
        phase_d      = bus.BLINK_TICK ? ~phase_q : phase_q;
        tmo_d        = tmo_q;
        sec_resetl_d = 1'b1;
        field_inc_d  = '0;
        new_idx      = '0;
        in_set       = (state_q != SW_W'(ST_NORMAL));

        if (!in_set) begin
            tmo_d = '0;
            if (e1) begin
                state_d = SW_W'(1);
                phase_d = 1'b1;
            end
        end else begin
            // cur_field_q mirrors state_q-1 while in SET, so it doubles as the field index
            if (e1) begin
                state_d = SW_W'(ST_NORMAL);
            end else if (e3) begin
                new_idx = (cur_field_q == '0) ? CW'(NFIELD - 1) : cur_field_q - 1'b1;
                state_d = SW_W'(new_idx) + SW_W'(1);
                phase_d = 1'b1;
            end else if (e2) begin
                phase_d = 1'b1;
                if (cur_field_q == CW'(FIELD_SEC)) begin
                    sec_resetl_d = 1'b0;
                end else begin
                    field_inc_d[cur_field_q] = 1'b1;
                end
            end

            if (e1 || e2 || e3) begin
                tmo_d = '0;
            end else if (TIMEOUT != 0 && bus.SEC_TICK) begin
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = SW_W'(ST_NORMAL);
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        end

`ifdef CLOCK_SET_REPEAT_EN
        hold_d = hold_q;
        if (!in_set || e2 || !bus.SW2 || (state_d != state_q) ||
            (cur_field_q == CW'(FIELD_SEC))) begin
            hold_d = '0;
        end else if (bus.BLINK_TICK) begin
            if (hold_q == HW'(REPEAT_DELAY)) begin
                field_inc_d[cur_field_q] = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
`endif

        // Display-side outputs are registered from the next state so they line up with it
        set_mode_d    = (state_d != SW_W'(ST_NORMAL));
        cur_field_d   = set_mode_d ? CW'(state_d - SW_W'(1)) : '0;
        field_onoff_d = '1;
        if (set_mode_d) begin
            field_onoff_d[cur_field_d] = phase_d;
        end
    end

    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            state_q       <= SW_W'(ST_NORMAL);
            phase_q       <= 1'b1;
            tmo_q         <= '0;
            sec_resetl_q  <= 1'b1;
            field_inc_q   <= '0;
            field_onoff_q <= '1;
            set_mode_q    <= 1'b0;
            cur_field_q   <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            tmo_q         <= tmo_d;
            sec_resetl_q  <= sec_resetl_d;
            field_inc_q   <= field_inc_d;
            field_onoff_q <= field_onoff_d;
            set_mode_q    <= set_mode_d;
            cur_field_q   <= cur_field_d;
        end
    end

`ifdef CLOCK_SET_REPEAT_EN
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign bus.sec_resetl  = sec_resetl_q;
    assign bus.field_inc   = field_inc_q;
    assign bus.field_onoff = field_onoff_q;
    assign bus.set_mode    = set_mode_q;
    assign bus.cur_field   = cur_field_q;

endmodule
